// File: rtl/hams_merge_tree.sv
// N-way streaming merge tree: per-way leaf FIFOs feed a heap-indexed tree of
// registered 2-to-1 merge nodes; node 1 is the root, leaves sit at NUM_WAYS+w.

module hams_merge_leaf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_lst,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_lst
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [AW:0]     r_cnt;
    logic            w_push, w_pop;

    assign o_full = (r_cnt == (AW+1)'(DEPTH));
    assign o_vld  = (r_cnt != '0);
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & o_vld;
    assign {o_lst, o_dat} = r_mem[r_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Storage carries no reset; validity lives entirely in r_cnt.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {i_lst, i_dat};
    end
endmodule

module hams_merge_node #(
    parameter int DATA_W = 64,
    parameter int KEY_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_desc,
    input  logic              i_a_vld,
    input  logic [DATA_W-1:0] i_a_dat,
    input  logic              i_a_lst,
    input  logic              i_a_dis,
    input  logic              i_b_vld,
    input  logic [DATA_W-1:0] i_b_dat,
    input  logic              i_b_lst,
    input  logic              i_b_dis,
    output logic              o_a_pop,
    output logic              o_b_pop,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_lst,
    input  logic              i_pop
);
    logic              r_done_a, r_done_b;
    logic [DATA_W-1:0] r_dat [2];
    logic [1:0]        r_lst;
    logic              r_wp, r_rp;
    logic [1:0]        r_cnt;

    logic              w_da, w_db, w_av, w_bv, w_a_wins;
    logic              w_push, w_pop, w_src_lst, w_other_done;
    logic [DATA_W-1:0] w_src_dat;
    logic [KEY_W-1:0]  w_ka, w_kb;

    // A disabled subtree looks permanently done to its parent.
    assign w_da     = r_done_a | i_a_dis;
    assign w_db     = r_done_b | i_b_dis;
    // A head behind a done flag belongs to the next run and must wait.
    assign w_av     = i_a_vld & ~w_da;
    assign w_bv     = i_b_vld & ~w_db;
    assign w_ka     = i_a_dat[KEY_W-1:0];
    assign w_kb     = i_b_dat[KEY_W-1:0];
    assign w_a_wins = i_desc ? (w_ka >= w_kb) : (w_ka <= w_kb);

    always_comb begin
        o_a_pop = 1'b0;
        o_b_pop = 1'b0;
        if (r_cnt != 2'd2) begin
            if (w_av && w_bv) begin
                o_a_pop = w_a_wins;
                o_b_pop = ~w_a_wins;
            end else if (w_av && w_db) begin
                o_a_pop = 1'b1;
            end else if (w_bv && w_da) begin
                o_b_pop = 1'b1;
            end
        end
    end

    assign w_push       = o_a_pop | o_b_pop;
    assign w_src_dat    = o_a_pop ? i_a_dat : i_b_dat;
    assign w_src_lst    = o_a_pop ? i_a_lst : i_b_lst;
    assign w_other_done = o_a_pop ? w_db : w_da;
    assign o_vld        = (r_cnt != 2'd0);
    assign w_pop        = i_pop & o_vld;
    assign o_dat        = r_dat[r_rp];
    assign o_lst        = r_lst[r_rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            r_dat[0] <= '0;
            r_dat[1] <= '0;
            r_lst    <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_dat[r_wp] <= w_src_dat;
                r_lst[r_wp] <= w_src_lst & w_other_done;
                r_wp        <= ~r_wp;
                if (w_src_lst) begin
                    if (w_other_done) begin
                        r_done_a <= 1'b0;
                        r_done_b <= 1'b0;
                    end else if (o_a_pop) begin
                        r_done_a <= 1'b1;
                    end else begin
                        r_done_b <= 1'b1;
                    end
                end
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule

module hams_merge_tree #(
    parameter int NUM_WAYS   = 4,
    parameter int DATA_W     = 64,
    parameter int KEY_W      = 32,
    parameter int LEAF_DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WAYS-1:0]        i_way_ena,
    input  logic                       i_descending,
    input  logic [NUM_WAYS-1:0]        i_in_valid,
    output logic [NUM_WAYS-1:0]        o_in_ready,
    input  logic [NUM_WAYS*DATA_W-1:0] i_in_data,
    input  logic [NUM_WAYS-1:0]        i_in_last,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [DATA_W-1:0]          o_out_data,
    output logic                       o_out_last,
    output logic                       o_busy,
    output logic [15:0]                o_runs_done
);
    localparam int NN = 2 * NUM_WAYS;

    logic              w_vld [1:NN-1];
    logic [DATA_W-1:0] w_dat [1:NN-1];
    logic              w_lst [1:NN-1];
    logic              w_pop [1:NN-1];
    logic              w_dis [1:NN-1];
    logic [NUM_WAYS-1:0] w_leaf_nemp;
    logic [NUM_WAYS-1:1] w_node_nemp;
    logic              r_desc;
    logic [15:0]       r_runs;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_leaf
        logic w_full, w_hv;
        hams_merge_leaf #(.DATA_W(DATA_W), .DEPTH(LEAF_DEPTH)) u_leaf (
            .clk    (clk),
            .rst    (rst),
            .i_push (i_in_valid[w]),
            .i_dat  (i_in_data[w*DATA_W +: DATA_W]),
            .i_lst  (i_in_last[w]),
            .i_pop  (w_pop[NUM_WAYS+w]),
            .o_full (w_full),
            .o_vld  (w_hv),
            .o_dat  (w_dat[NUM_WAYS+w]),
            .o_lst  (w_lst[NUM_WAYS+w])
        );
        assign o_in_ready[w]      = ~w_full;
        assign w_leaf_nemp[w]     = w_hv;
        assign w_vld[NUM_WAYS+w]  = w_hv & i_way_ena[w];
        assign w_dis[NUM_WAYS+w]  = ~i_way_ena[w];
    end

    // Node n merges children 2n (A, lower ways) and 2n+1 (B).
    for (genvar n = 1; n < NUM_WAYS; n++) begin : g_node
        hams_merge_node #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_node (
            .clk     (clk),
            .rst     (rst),
            .i_desc  (r_desc),
            .i_a_vld (w_vld[2*n]),
            .i_a_dat (w_dat[2*n]),
            .i_a_lst (w_lst[2*n]),
            .i_a_dis (w_dis[2*n]),
            .i_b_vld (w_vld[2*n+1]),
            .i_b_dat (w_dat[2*n+1]),
            .i_b_lst (w_lst[2*n+1]),
            .i_b_dis (w_dis[2*n+1]),
            .o_a_pop (w_pop[2*n]),
            .o_b_pop (w_pop[2*n+1]),
            .o_vld   (w_vld[n]),
            .o_dat   (w_dat[n]),
            .o_lst   (w_lst[n]),
            .i_pop   (w_pop[n])
        );
        assign w_dis[n]       = w_dis[2*n] & w_dis[2*n+1];
        assign w_node_nemp[n] = w_vld[n];
    end

    assign w_pop[1]    = w_vld[1] & i_out_ready;
    assign o_out_valid = w_vld[1];
    assign o_out_data  = w_dat[1];
    assign o_out_last  = w_lst[1];
    assign o_busy      = (|w_leaf_nemp) | (|w_node_nemp);
    assign o_runs_done = r_runs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_desc <= 1'b0;
            r_runs <= '0;
        end else begin
            if (!o_busy) r_desc <= i_descending;
            if (w_pop[1] && w_lst[1]) r_runs <= r_runs + 16'd1;
        end
    end
endmodule

// File: tb/tb_hams_merge_tree.sv
// Directed bench for hams_merge_tree (4 ways, shallow leaves to exercise back-pressure).

module tb_hams_merge_tree;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NW-1:0] way_ena, in_valid, in_ready, in_last;
    logic          descending, out_valid, out_ready, out_last, busy;
    logic [NW*64-1:0] in_data;
    logic [63:0]   out_data;
    logic [15:0]   runs_done;

    logic [64:0] wmem [NW][0:1023];
    int          wlen [NW];
    int          wptr [NW];
    int          wstart [NW];
    logic [64:0] expv [0:4095];
    int          nexp, ngot, nlast, first_vld;
    int          n_chk = 0, n_pass = 0;

    hams_merge_tree #(.NUM_WAYS(NW), .DATA_W(64), .KEY_W(32), .LEAF_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_way_ena    (way_ena),
        .i_descending (descending),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .i_in_last    (in_last),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_last   (out_last),
        .o_busy       (busy),
        .o_runs_done  (runs_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clr();
        for (int w = 0; w < NW; w++) begin
            wlen[w] = 0; wptr[w] = 0; wstart[w] = 0;
        end
        nexp = 0;
    endtask

    task automatic put(input int w, input int key, input bit last, input int tag);
        wmem[w][wlen[w]] = {last, 32'(tag), 32'(key)};
        wlen[w]++;
    endtask

    task automatic ex(input int key, input bit last, input int tag);
        expv[nexp] = {last, 32'(tag), 32'(key)};
        nexp++;
    endtask

    // Cycle loop: drive at negedge, decide handshakes from pre-edge values,
    // retire them after the following posedge.
    task automatic run(input string tag, input int max_cyc, input bit rnd, input int stop_at);
        logic [NW-1:0] push;
        logic          ohs;
        logic [64:0]   od;
        ngot = 0; nlast = 0; first_vld = -1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            for (int w = 0; w < NW; w++) begin
                if (c >= wstart[w] && wptr[w] < wlen[w]) begin
                    in_valid[w]         = 1'b1;
                    in_data[w*64 +: 64] = wmem[w][wptr[w]][63:0];
                    in_last[w]          = wmem[w][wptr[w]][64];
                end else begin
                    in_valid[w] = 1'b0;
                    in_last[w]  = 1'b0;
                end
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            push = in_valid & in_ready;
            ohs  = out_valid & out_ready;
            od   = {out_last, out_data};
            if (out_valid && first_vld < 0) first_vld = c;
            @(posedge clk);
            for (int w = 0; w < NW; w++) if (push[w]) wptr[w]++;
            if (ohs) begin
                if (ngot < nexp) chk(tag, od, expv[ngot]);
                ngot++;
                if (od[64]) nlast++;
            end
            if (nexp > 0 && ngot == nexp) break;
            if (c == stop_at) break;
        end
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        if (stop_at < 0) chk({tag, "_count"}, 65'(ngot), 65'(nexp));
    endtask

    task automatic idle_chk(input string tag);
        repeat (3) @(negedge clk);
        #1;
        chk(tag, {63'd0, out_valid, busy}, 65'd0);
    endtask

    task automatic load_basic();
        clr();
        put(0, 1, 0, 'h00); put(0, 5, 0, 'h01); put(0, 9, 1, 'h02);
        put(1, 2, 0, 'h10); put(1, 6, 1, 'h11);
        put(2, 3, 0, 'h20); put(2, 7, 0, 'h21); put(2, 8, 1, 'h22);
        put(3, 4, 1, 'h30);
        ex(1, 0, 'h00); ex(2, 0, 'h10); ex(3, 0, 'h20); ex(4, 0, 'h30); ex(5, 0, 'h01);
        ex(6, 0, 'h11); ex(7, 0, 'h21); ex(8, 0, 'h22); ex(9, 1, 'h02);
    endtask

    // Reference: repeatedly take the smallest head, lowest way index on ties.
    task automatic load_bp();
        int p [NW];
        int key, bw, k0;
        logic [64:0] e;
        clr();
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < NW; w++) begin
                key = $urandom_range(0, 10);
                for (int i = 0; i < 200; i++) begin
                    put(w, key, i == 199, (w << 24) | (r << 16) | i);
                    key = key + $urandom_range(0, 3);
                end
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int w = 0; w < NW; w++) p[w] = 0;
            for (int k = 0; k < 800; k++) begin
                bw = -1;
                for (int w = 0; w < NW; w++) begin
                    if (p[w] < 200) begin
                        if (bw < 0) bw = w;
                        else begin
                            k0 = int'(wmem[bw][r*200+p[bw]][31:0]);
                            if (int'(wmem[w][r*200+p[w]][31:0]) < k0) bw = w;
                        end
                    end
                end
                e = wmem[bw][r*200+p[bw]];
                p[bw]++;
                e[64] = (k == 799);
                expv[nexp] = e;
                nexp++;
            end
        end
    endtask

    initial begin
        way_ena = '1; descending = 1'b0; in_valid = '0; in_last = '0;
        in_data = '0; out_ready = 1'b1;
        clr();

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        chk("rst_out_last",  65'(out_last),  65'd0);
        chk("rst_out_data",  65'(out_data),  65'd0);
        chk("rst_runs",      65'(runs_done), 65'd0);
        chk("rst_busy",      65'(busy),      65'd0);
        chk("rst_in_ready",  65'(in_ready),  65'hF);
        rst = 1'b0;

        load_basic();
        run("basic", 200, 1'b0, -1);
        idle_chk("basic_idle");
        chk("basic_runs", 65'(runs_done), 65'd1);

        clr(); way_ena = 4'b0011;
        put(0, 5, 0, 'hA); put(0, 5, 1, 'hB); put(1, 5, 1, 'hC);
        ex(5, 0, 'hA); ex(5, 0, 'hB); ex(5, 1, 'hC);
        run("tie", 200, 1'b0, -1);
        idle_chk("tie_idle");
        chk("tie_runs", 65'(runs_done), 65'd2);

        clr();
        put(0, 1, 0, 'h01); put(0, 2, 0, 'h02); put(0, 3, 1, 'h03);
        put(1, 0, 1, 'h10);
        wstart[1] = 20;
        ex(0, 0, 'h10); ex(1, 0, 'h01); ex(2, 0, 'h02); ex(3, 1, 'h03);
        run("slow", 300, 1'b0, -1);
        chk("slow_latency", 65'(first_vld), 65'd23);
        idle_chk("slow_idle");

        clr(); way_ena = 4'b1011; descending = 1'b1;
        @(negedge clk);
        put(0, 9, 0, 'h00); put(0, 4, 1, 'h01);
        put(1, 7, 1, 'h10);
        put(3, 8, 0, 'h30); put(3, 1, 1, 'h31);
        ex(9, 0, 'h00); ex(8, 0, 'h30); ex(7, 0, 'h10); ex(4, 0, 'h01); ex(1, 1, 'h31);
        run("desc", 200, 1'b0, -1);
        idle_chk("desc_idle");
        chk("desc_runs", 65'(runs_done), 65'd4);
        descending = 1'b0; way_ena = 4'b1111;
        @(negedge clk);

        load_bp();
        run("bp", 20000, 1'b1, -1);
        chk("bp_lasts", 65'(nlast), 65'd4);
        idle_chk("bp_idle");
        chk("bp_runs", 65'(runs_done), 65'd8);

        clr(); way_ena = 4'b0000;
        put(0, 3, 1, 'h77);
        run("alldis", 30, 1'b0, 29);
        chk("alldis_no_valid", 65'(first_vld), 65'(-1));
        chk("alldis_runs", 65'(runs_done), 65'd8);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; way_ena = 4'b1111;
        idle_chk("alldis_rst_idle");
        chk("alldis_rst_runs", 65'(runs_done), 65'd0);

        load_basic();
        run("midrun", 200, 1'b0, 4);
        @(negedge clk);
        chk("midrun_busy", 65'(busy), 65'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", 65'(out_valid), 65'd0);
        chk("midrun_rst_busy",  65'(busy),      65'd0);
        chk("midrun_rst_runs",  65'(runs_done), 65'd0);
        chk("midrun_rst_ready", 65'(in_ready),  65'hF);
        @(negedge clk); rst = 1'b0;

        load_basic();
        run("post_rst", 200, 1'b0, -1);
        idle_chk("post_rst_idle");
        chk("post_rst_runs", 65'(runs_done), 65'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
